lorenz_decrypt: RTL

LORENZ_DECRYPT -- requirements
Module: lorenz_decrypt

---
 rtl/lorenz_decrypt.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lorenz_decrypt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lorenz_decrypt                                             |
// | Description : In-place image decryptor. Undoes a three-stage chaotic     |
// |               encryption over an N = 2^ADDR_W word image RAM:            |
// |                 P1 un-swap with key z, descending index                  |
// |                 P2 XOR with key y, ascending index                       |
// |                 P3 un-swap with key x, descending index                  |
// |               Swap steps take 6 cycles per index, XOR steps 3 cycles,    |
// |               so an operation keeps busy high for exactly 15*N cycles.   |
// | Ports       : clk, reset (sync, active-high), start (1-cycle request)    |
// |               busy / done          status, done is a 1-cycle pulse       |
// |               key_sel/key_addr     key RAM read port (0=x, 1=y, 2=z)     |
// |               key_rdata            key RAM data, 1 cycle after address  |
// |               img_addr/img_we/     image RAM port; read data arrives     |
// |               img_wdata/img_rdata  one cycle after the address          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lorenz_decrypt #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        key_sel,
  output logic [ADDR_W-1:0] key_addr,
  input  logic [DATA_W-1:0] key_rdata,
  output logic [ADDR_W-1:0] img_addr,
  output logic              img_we,
  output logic [DATA_W-1:0] img_wdata,
  input  logic [DATA_W-1:0] img_rdata
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SW_KEY = 4'd1;
  localparam logic [3:0] S_SW_RDA = 4'd2;
  localparam logic [3:0] S_SW_RDB = 4'd3;
  localparam logic [3:0] S_SW_CAP = 4'd4;
  localparam logic [3:0] S_SW_WRA = 4'd5;
  localparam logic [3:0] S_SW_WRB = 4'd6;
  localparam logic [3:0] S_DF_RD  = 4'd7;
  localparam logic [3:0] S_DF_CAP = 4'd8;
  localparam logic [3:0] S_DF_WR  = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;

  localparam logic [1:0] c_P1 = 2'd0;
  localparam logic [1:0] c_P2 = 2'd1;
  localparam logic [1:0] c_P3 = 2'd2;

  localparam logic [1:0] c_KEY_X = 2'd0;
  localparam logic [1:0] c_KEY_Y = 2'd1;
  localparam logic [1:0] c_KEY_Z = 2'd2;

  // Explicit terminal compares on an ADDR_W counter: no wrap-around aliasing.
  localparam logic [ADDR_W-1:0] c_ZERO = '0;
  localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [1:0]        r_phase;
  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_x;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SW_KEY;
      S_SW_KEY: w_next = S_SW_RDA;
      S_SW_RDA: w_next = S_SW_RDB;
      S_SW_RDB: w_next = S_SW_CAP;
      S_SW_CAP: w_next = S_SW_WRA;
      S_SW_WRA: w_next = S_SW_WRB;
      S_SW_WRB: begin
        if (r_i != c_ZERO)       w_next = S_SW_KEY;
        else if (r_phase == c_P1) w_next = S_DF_RD;
        else                      w_next = S_DONE;
      end
      S_DF_RD:  w_next = S_DF_CAP;
      S_DF_CAP: w_next = S_DF_WR;
      S_DF_WR:  w_next = (r_i == c_LAST) ? S_SW_KEY : S_DF_RD;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: index, phase and captured words
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i     <= c_ZERO;
      r_phase <= c_P1;
      r_j     <= c_ZERO;
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i     <= c_LAST;
            r_phase <= c_P1;
          end
        end
        // Only the low ADDR_W key bits form the swap partner index.
        S_SW_RDA: r_j <= key_rdata[ADDR_W-1:0];
        S_SW_RDB: r_a <= img_rdata;
        S_SW_CAP: r_b <= img_rdata;
        S_SW_WRB: begin
          if (r_i != c_ZERO)        r_i     <= r_i - c_ONE;
          else if (r_phase == c_P1) r_phase <= c_P2;  // XOR pass starts at i=0
        end
        S_DF_CAP: r_x <= img_rdata ^ key_rdata;
        S_DF_WR: begin
          if (r_i == c_LAST) r_phase <= c_P3;         // un-swap x starts at N-1
          else               r_i     <= r_i + c_ONE;
        end
        default: ;
      endcase
    end
  end

  // Output logic (Moore)
  always_comb begin
    busy      = 1'b1;
    done      = 1'b0;
    key_sel   = c_KEY_X;
    key_addr  = c_ZERO;
    img_addr  = c_ZERO;
    img_we    = 1'b0;
    img_wdata = '0;
    case (r_state)
      S_IDLE: busy = 1'b0;
      S_SW_KEY: begin
        key_sel  = (r_phase == c_P1) ? c_KEY_Z : c_KEY_X;
        key_addr = r_i;
      end
      S_SW_RDA: img_addr = r_i;
      S_SW_RDB: img_addr = r_j;
      S_SW_CAP: ;
      // Writing a to j then b to i: when j == i the second write restores
      // the original word, so the identity swap needs no special case.
      S_SW_WRA: begin
        img_we    = 1'b1;
        img_addr  = r_j;
        img_wdata = r_a;
      end
      S_SW_WRB: begin
        img_we    = 1'b1;
        img_addr  = r_i;
        img_wdata = r_b;
      end
      S_DF_RD: begin
        key_sel  = c_KEY_Y;
        key_addr = r_i;
        img_addr = r_i;
      end
      S_DF_CAP: ;
      S_DF_WR: begin
        img_we    = 1'b1;
        img_addr  = r_i;
        img_wdata = r_x;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule
`default_nettype wire
